// File: rtl/board_writer.sv
// board_writer
// Owns the 8x8 battleship board. Debounced button levels are edge-detected
// and turned into cursor moves and cell writes: ships are placed first, then
// shots are resolved against them. The renderer reads any cell through an
// asynchronous read port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   btn_u/d/l/r/c       debounced button levels (up, down, left, right, action)
//   commit              debounced level; rising edge ends placement
//   rd_x, rd_y          renderer read address
//   rd_cell             cell at (rd_x, rd_y): 0 empty, 1 ship, 2 miss, 3 hit
//   cursor_x, cursor_y  cursor position (row 0 is the top)
//   phase               0 PLACE, 1 ATTACK, 2 DONE
//   ship_count          ship cells placed
//   hit_count           hits scored
//   shot_count          resolved shots, saturating at 255
//   wr_strobe           one-cycle pulse in the cycle after a board write
module board_writer #(
  parameter int SHIP_CELLS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       commit,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [1:0] rd_cell,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic [1:0] phase,
  output logic [6:0] ship_count,
  output logic [6:0] hit_count,
  output logic [7:0] shot_count,
  output logic       wr_strobe
);

  localparam logic [6:0] SHIP_MAX = 7'(SHIP_CELLS);

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_SHIP  = 2'd1;
  localparam logic [1:0] CELL_MISS  = 2'd2;
  localparam logic [1:0] CELL_HIT   = 2'd3;

  typedef enum logic [1:0] {
    PH_PLACE  = 2'd0,
    PH_ATTACK = 2'd1,
    PH_DONE   = 2'd2
  } phase_t;

  phase_t     state;
  logic [1:0] board [64];

  logic prev_u, prev_d, prev_l, prev_r, prev_c, prev_commit;
  logic press_u, press_d, press_l, press_r, press_c, press_commit;

  logic [5:0] cur_idx;
  logic [1:0] cur_cell;
  logic [2:0] next_x;
  logic [2:0] next_y;

  // Shot counter holds at its top value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    press_u      = btn_u & ~prev_u;
    press_d      = btn_d & ~prev_d;
    press_l      = btn_l & ~prev_l;
    press_r      = btn_r & ~prev_r;
    press_c      = btn_c & ~prev_c;
    press_commit = commit & ~prev_commit;

    cur_idx  = {cursor_y, cursor_x};
    cur_cell = board[cur_idx];

    // Opposing presses in the same cycle cancel; 3-bit arithmetic wraps mod 8.
    next_x = cursor_x;
    if (press_l && !press_r)      next_x = cursor_x - 3'd1;
    else if (press_r && !press_l) next_x = cursor_x + 3'd1;

    next_y = cursor_y;
    if (press_u && !press_d)      next_y = cursor_y - 3'd1;
    else if (press_d && !press_u) next_y = cursor_y + 3'd1;
  end

  // Board is already cleared asynchronously; the gate keeps the read at 0
  // for the whole time rst is held regardless of address.
  assign rd_cell = rst ? CELL_EMPTY : board[{rd_y, rd_x}];
  assign phase   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) board[i] <= CELL_EMPTY;
      state       <= PH_PLACE;
      cursor_x    <= 3'd0;
      cursor_y    <= 3'd0;
      ship_count  <= 7'd0;
      hit_count   <= 7'd0;
      shot_count  <= 8'd0;
      wr_strobe   <= 1'b0;
      prev_u      <= 1'b0;
      prev_d      <= 1'b0;
      prev_l      <= 1'b0;
      prev_r      <= 1'b0;
      prev_c      <= 1'b0;
      prev_commit <= 1'b0;
    end else begin
      prev_u      <= btn_u;
      prev_d      <= btn_d;
      prev_l      <= btn_l;
      prev_r      <= btn_r;
      prev_c      <= btn_c;
      prev_commit <= commit;

      // The write below uses cur_idx, i.e. the pre-move cursor.
      cursor_x  <= next_x;
      cursor_y  <= next_y;
      wr_strobe <= 1'b0;

      case (state)
        PH_PLACE: begin
          if (press_c) begin
            if (cur_cell == CELL_EMPTY && ship_count < SHIP_MAX) begin
              board[cur_idx] <= CELL_SHIP;
              ship_count     <= ship_count + 7'd1;
              wr_strobe      <= 1'b1;
            end else if (cur_cell == CELL_SHIP) begin
              board[cur_idx] <= CELL_EMPTY;
              ship_count     <= ship_count - 7'd1;
              wr_strobe      <= 1'b1;
            end
          end
          // ship_count here is the pre-write value.
          if (press_commit && ship_count == SHIP_MAX) state <= PH_ATTACK;
        end
        PH_ATTACK: begin
          if (press_c) begin
            if (cur_cell == CELL_EMPTY) begin
              board[cur_idx] <= CELL_MISS;
              shot_count     <= sat_inc8(shot_count);
              wr_strobe      <= 1'b1;
            end else if (cur_cell == CELL_SHIP) begin
              board[cur_idx] <= CELL_HIT;
              hit_count      <= hit_count + 7'd1;
              shot_count     <= sat_inc8(shot_count);
              wr_strobe      <= 1'b1;
              if (hit_count + 7'd1 == SHIP_MAX) state <= PH_DONE;
            end
          end
        end
        default: begin
          // DONE: board and counters frozen, only the cursor moves.
        end
      endcase
    end
  end

endmodule

// File: doc/board_writer.md
# board_writer

Game-board state owner for the battleship design. Turns debounced button levels into cursor moves and cell writes on an 8x8 board: ship placement first, then shot resolution. Exposes an asynchronous read port so the VGA renderer, which reads the board, can fetch any cell at pixel rate.

## Interface

Parameters:
- SHIP_CELLS, 17, number of ship cells that must be placed before commit; legal range 1..64.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- btn_u  in  1  debounced up button, level.
- btn_d  in  1  debounced down button, level.
- btn_l  in  1  debounced left button, level.
- btn_r  in  1  debounced right button, level.
- btn_c  in  1  debounced center (action) button, level.
- commit  in  1  debounced level; a rising edge ends placement.
- rd_x  in  3  read column for the renderer.
- rd_y  in  3  read row for the renderer.
- rd_cell  out  2  cell at (rd_x, rd_y), combinational: 0 empty, 1 ship, 2 miss, 3 hit.
- cursor_x  out  3  cursor column.
- cursor_y  out  3  cursor row; row 0 is the top.
- phase  out  2  0 PLACE, 1 ATTACK, 2 DONE.
- ship_count  out  7  ship cells placed.
- hit_count  out  7  hits scored.
- shot_count  out  8  resolved shots, saturating at 255.
- wr_strobe  out  1  one-cycle pulse in the cycle after any board write.

## Operation

- Edge detection: each button input and commit has a registered previous value, reset to 0. A press is `level & ~prev`. Each physical press acts exactly once. A level already high when reset releases counts as a press on the first clock.
- Cursor: U decrements y, D increments y, L decrements x, R increments x, all modulo 8 (0-1 gives 7, 7+1 gives 0).
  - U and D pressed in the same cycle: y unchanged.
  - L and R pressed in the same cycle: x unchanged.
  - Cursor moves in every phase, including DONE.
- PLACE:
  - C on an empty cell with ship_count < SHIP_CELLS: write 1 and increment ship_count.
  - C on a ship cell: write 0 and decrement ship_count.
  - C on an empty cell with ship_count == SHIP_CELLS: ignored.
  - Commit edge with ship_count == SHIP_CELLS: go to ATTACK.
  - Commit edge with any other count: ignored.
- ATTACK:
  - C on an empty cell: write 2 and increment shot_count.
  - C on a ship cell: write 3, increment hit_count and shot_count.
  - C on a miss or hit cell: no write, no count change.
  - Commit is ignored.
  - When a hit makes hit_count == SHIP_CELLS, go to DONE on that same clock edge.
- DONE: board and counters are frozen; C and commit are ignored; only the cursor moves. Only rst leaves DONE.
- C and a direction pressed in the same cycle: the write uses the pre-move cursor, and the cursor moves on the same edge.
- C and a commit edge in the same PLACE cycle: the write happens first, and commit is evaluated against the pre-write ship_count.
- Storage: 64 x 2-bit registers, all cleared by rst. Indexed as {y, x}.

## Timing

- Reset values: cursor 0,0; phase 0; all counts 0; wr_strobe 0; every cell 0. With rst asserted, rd_cell is 0 for any address.
- Reset is asynchronous, so assertion mid-game clears everything immediately, with no clock needed.
- Press to effect: a press detected at edge N updates cursor, cell, counts and phase, all visible after edge N. wr_strobe is high for the cycle after edge N.
- rd_cell has zero-cycle latency from rd_x/rd_y and reflects a write from the edge it occurs.
- A held button produces no further action until it is released and pressed again (release for at least one cycle).

## Test plan

- Reset, then hold L for one press -> cursor_x=7, cursor_y=0. Press U -> cursor_y=7. Press U and D together -> cursor_y stays 7.
- SHIP_CELLS=2: C at (0,0), C at (1,0), C at (2,0) -> ship_count=2, cell (2,0)=0. C at (1,0) -> cell 0, ship_count=1. Commit -> phase stays 0.
- SHIP_CELLS=2: place (0,0) and (1,0), commit -> phase=1. C at (5,5) -> rd_cell(5,5)=2, shot_count=1. C at (5,5) again -> no change, no wr_strobe.
- Continue: C at (0,0) -> hit_count=1. C at (1,0) -> hit_count=2, phase=2 on the same edge. A further C at (3,3) -> cell stays 0, shot_count stays 3.
- Press C together with R at (3,4) in PLACE -> cell (3,4)=1, cursor_x=4. Hold C for 100 cycles -> exactly one write.
- Assert rst mid-ATTACK between clock edges -> all outputs and every rd_cell read go to 0 before the next clk edge.
